// File: rtl/ddc_stream.sv
// ddc_stream: NCHAN-channel digital down-converter. Each real ADC channel is
// mixed with a shared cos/sin LO, the I and Q products are boxcar-integrated
// over a programmable window, then scaled, saturated and serialised as a
// tagged valid/ready word stream. Frames are dropped and counted when a new
// window completes while the previous frame is still being drained.

// Per-channel datapath: mixer, I/Q integrate-and-dump, scale and saturate.
module ddc_lane #(
  parameter int DW   = 16,
  parameter int OSCW = 18,
  parameter int ACCW = 48,
  parameter int RW   = 20
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic signed [DW-1:0]   i_adc,
  input  logic signed [OSCW-1:0] i_cos,
  input  logic signed [OSCW-1:0] i_sin,
  input  logic                   i_run,
  input  logic                   i_dump,
  input  logic [5:0]             i_shift,
  output logic [RW-1:0]          o_res_i,
  output logic [RW-1:0]          o_res_q
);
  localparam int PW = DW + OSCW;
  localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-RW+1){1'b0}}, {(RW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-RW+1){1'b1}}, {(RW-1){1'b0}}};

  logic signed [PW-1:0]   r_pi, r_pq;
  logic signed [ACCW-1:0] r_acc_i, r_acc_q, r_hold_i, r_hold_q;
  logic signed [ACCW-1:0] w_pi_x, w_pq_x;

  // Arithmetic shift floors toward -inf; shifts past the accumulator width
  // collapse to the sign, which the clamp then passes through unchanged.
  function automatic logic [RW-1:0] f_scale(input logic signed [ACCW-1:0] v,
                                            input logic [5:0] sh);
    logic signed [ACCW-1:0] s;
    s = v >>> sh;
    if (s > SMAX)      f_scale = SMAX[RW-1:0];
    else if (s < SMIN) f_scale = SMIN[RW-1:0];
    else               f_scale = s[RW-1:0];
  endfunction

  assign w_pi_x  = {{(ACCW-PW){r_pi[PW-1]}}, r_pi};
  assign w_pq_x  = {{(ACCW-PW){r_pq[PW-1]}}, r_pq};
  assign o_res_i = f_scale(r_hold_i, i_shift);
  assign o_res_q = f_scale(r_hold_q, i_shift);

  // Mixer: full-precision signed products, one register stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pi <= '0;
      r_pq <= '0;
    end else begin
      r_pi <= $signed({{OSCW{i_adc[DW-1]}}, i_adc}) * $signed({{DW{i_cos[OSCW-1]}}, i_cos});
      r_pq <= $signed({{OSCW{i_adc[DW-1]}}, i_adc}) * $signed({{DW{i_sin[OSCW-1]}}, i_sin});
    end
  end

  // Integrate-and-dump: the dump cycle's product lands in hold, so every
  // window sums exactly P products with none lost across the boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc_i  <= '0;
      r_acc_q  <= '0;
      r_hold_i <= '0;
      r_hold_q <= '0;
    end else if (i_run) begin
      if (i_dump) begin
        r_hold_i <= r_acc_i + w_pi_x;
        r_hold_q <= r_acc_q + w_pq_x;
        r_acc_i  <= '0;
        r_acc_q  <= '0;
      end else begin
        r_acc_i  <= r_acc_i + w_pi_x;
        r_acc_q  <= r_acc_q + w_pq_x;
      end
    end
  end
endmodule

// Top: shared window counter, channel lanes, frame serializer and drop stats.
module ddc_stream #(
  parameter int NCHAN = 8,
  parameter int DW    = 16,
  parameter int OSCW  = 18,
  parameter int ACCW  = 48,
  parameter int RW    = 20,
  parameter int PCW   = 13,
  parameter int CHW   = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NCHAN*DW-1:0]    adcs,
  input  logic signed [OSCW-1:0] cosa,
  input  logic signed [OSCW-1:0] sina,
  input  logic [PCW-1:0]         cic_period,
  input  logic [5:0]             cic_shift,
  input  logic [NCHAN-1:0]       chan_en,
  output logic [RW-1:0]          out_data,
  output logic [CHW-1:0]         out_chan,
  output logic                   out_q,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   frame_drop,
  output logic [15:0]            drop_count
);
  localparam logic [0:0]     ST_IDLE = 1'b0;
  localparam logic [0:0]     ST_SEND = 1'b1;
  localparam logic [PCW-1:0] P_MIN   = PCW'(2);
  localparam logic [PCW-1:0] P_ONE   = PCW'(1);

  logic                         r_run;
  logic [PCW-1:0]               r_cnt, r_per;
  logic [PCW-1:0]               w_per_in;
  logic                         w_dump;
  logic                         r_dump_d;
  logic [NCHAN-1:0][RW-1:0]     w_res_i, w_res_q;
  logic [NCHAN-1:0][RW-1:0]     r_sh_i, r_sh_q;
  logic [0:0]                   r_state;
  logic [CHW-1:0]               r_ch, r_lastch;
  logic                         r_q;
  logic [NCHAN-1:0]             r_mask;
  logic                         r_drop;
  logic [15:0]                  r_dcnt;
  logic [CHW-1:0]               w_first, w_high, w_next;
  logic                         w_hs, w_fin, w_load, w_drop;

  assign w_per_in = (cic_period < P_MIN) ? P_MIN : cic_period;
  assign w_dump   = r_run && (r_cnt == (r_per - P_ONE));

  // Window counter. The first cycle after reset only primes the product
  // registers and latches the period, so the first window is a full one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_per <= P_MIN;
    end else if (!r_run) begin
      r_run <= 1'b1;
      r_per <= w_per_in;
      r_cnt <= '0;
    end else if (w_dump) begin
      r_per <= w_per_in;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + P_ONE;
    end
  end

  // Dump delayed one cycle so the serializer sees the freshly written hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_dump_d <= 1'b0;
    else          r_dump_d <= w_dump;
  end

  for (genvar k = 0; k < NCHAN; k++) begin : g_lane
    ddc_lane #(.DW(DW), .OSCW(OSCW), .ACCW(ACCW), .RW(RW)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .i_adc   (adcs[k*DW +: DW]),
      .i_cos   (cosa),
      .i_sin   (sina),
      .i_run   (r_run),
      .i_dump  (w_dump),
      .i_shift (cic_shift),
      .o_res_i (w_res_i[k]),
      .o_res_q (w_res_q[k])
    );
  end

  // Lowest/highest enabled channel of the live mask, and the next enabled
  // channel above the current one in the frame's snapshot mask.
  always_comb begin
    w_first = '0;
    w_high  = '0;
    w_next  = '0;
    for (int k = NCHAN-1; k >= 0; k--) begin
      if (chan_en[k]) w_first = CHW'(k);
      if (r_mask[k] && (k > int'(r_ch))) w_next = CHW'(k);
    end
    for (int k = 0; k < NCHAN; k++) begin
      if (chan_en[k]) w_high = CHW'(k);
    end
  end

  assign out_valid = (r_state == ST_SEND);
  assign out_data  = r_q ? r_sh_q[r_ch] : r_sh_i[r_ch];
  assign out_chan  = r_ch;
  assign out_q     = r_q;
  assign out_last  = out_valid && r_q && (r_ch == r_lastch);

  assign w_hs   = out_valid && out_ready;
  assign w_fin  = w_hs && out_last;
  assign w_load = r_dump_d && ((r_state == ST_IDLE) || w_fin);
  assign w_drop = r_dump_d && (r_state == ST_SEND) && !w_fin;

  // Serializer: a new frame can start on the same cycle the previous one's
  // final word is accepted, so back-to-back frames keep valid high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_sh_i   <= '0;
      r_sh_q   <= '0;
      r_mask   <= '0;
      r_ch     <= '0;
      r_lastch <= '0;
      r_q      <= 1'b0;
    end else if (w_load) begin
      if (|chan_en) begin
        r_sh_i   <= w_res_i;
        r_sh_q   <= w_res_q;
        r_mask   <= chan_en;
        r_ch     <= w_first;
        r_lastch <= w_high;
        r_q      <= 1'b0;
        r_state  <= ST_SEND;
      end else begin
        r_state  <= ST_IDLE;
      end
    end else if (w_hs) begin
      if (out_last) begin
        r_state <= ST_IDLE;
      end else if (!r_q) begin
        r_q <= 1'b1;
      end else begin
        r_ch <= w_next;
        r_q  <= 1'b0;
      end
    end
  end

  // Drop pulse and saturating drop counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop <= 1'b0;
      r_dcnt <= '0;
    end else begin
      r_drop <= w_drop;
      if (w_drop && (r_dcnt != 16'hFFFF)) r_dcnt <= r_dcnt + 16'd1;
    end
  end

  assign frame_drop = r_drop;
  assign drop_count = r_dcnt;
endmodule

// File: doc/ddc_stream.md
Name: ddc_stream

Overview:
- Parametrised successor of the 4-channel vector-voltmeter DDC.
- NCHAN real ADC channels, each mixed with a shared cos/sin LO into I and Q.
- Each I/Q stream is boxcar-integrated over a programmable window, then dumped, scaled and saturated.
- Results leave as a valid/ready word stream with channel/IQ tags, a per-channel enable mask and overrun accounting; feeds the host FIFO / DMA path.

Parameters:
- NCHAN, 8, number of ADC channels.
- DW, 16, signed ADC sample width.
- OSCW, 18, signed LO width.
- ACCW, 48, accumulator width; must be >= DW+OSCW+PCW.
- RW, 20, signed result width.
- PCW, 13, period counter width.
- CHW, 3, channel index width; must be >= clog2(NCHAN).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- adcs  in  NCHAN*DW  packed signed samples, channel k at [k*DW +: DW].
- cosa  in  OSCW  signed LO cosine.
- sina  in  OSCW  signed LO sine.
- cic_period  in  PCW  integration window length in clk cycles.
- cic_shift  in  6  arithmetic right shift applied at dump.
- chan_en  in  NCHAN  per-channel output enable.
- out_data  out  RW  signed result word.
- out_chan  out  CHW  channel index of out_data.
- out_q  out  1  0 = I word, 1 = Q word.
- out_last  out  1  last word of frame.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- frame_drop  out  1  one-cycle pulse: frame discarded.
- drop_count  out  16  saturating count of dropped frames.

Behaviour:
- Reset (async assert, sync release): all accumulators, product regs, holding bank, counter, drop_count = 0; FSM IDLE; out_valid/out_last/frame_drop = 0; out_data/out_chan/out_q = 0.
- Mixer: p_i[k] = adc[k]*cosa, p_q[k] = adc[k]*sina, full DW+OSCW signed, registered (1 cycle).
- Period counter: counts 0..P-1, where P = max(cic_period, 2), and wraps to 0.
  - dump = (count == P-1).
  - cic_period is resampled only on the dump cycle; a change takes effect from the next window.
- Accumulate, sign-extended to ACCW:
  - Non-dump cycle: acc += p.
  - Dump cycle: hold <= acc + p; acc <= 0.
  - Each window therefore sums exactly P registered products; no sample is lost or double counted.
- Scale: r = hold >>> cic_shift (arithmetic, floor). Clamp to [-2^(RW-1), 2^(RW-1)-1]. Shift >= ACCW yields 0 or -1 by sign.
- Serializer FSM states: IDLE, SEND.
  - Dump while IDLE, or during SEND on the cycle the final word handshakes: copy hold to shadow bank, snapshot chan_en, enter SEND.
  - Snapshot mask all zero: no frame, stay IDLE, no drop.
  - Word order: I0,Q0,I1,Q1,... ascending channel, disabled channels skipped.
  - First out_valid is 2 cycles after the dump cycle.
  - Handshake = out_valid & out_ready. The word advances only on handshake; out_data/out_chan/out_q/out_last are held stable while valid & !ready.
  - out_last is high with the Q word of the highest enabled channel. Handshake on the last word returns to IDLE unless a dump coincides; in that case out_valid stays high continuously into the new frame.
  - Dump during SEND (not on the final handshake): new frame discarded, frame_drop = 1 for 1 cycle, drop_count += 1, saturating at 0xFFFF. The frame in flight is untouched.
- chan_en changes mid-frame have no effect until the next snapshot.
- Throughput: 1 word/cycle with out_ready held high. No drops when P >= 2*popcount(chan_en) + 2.

Test Plan:
- Baseline: all adc=1000, cosa=65536, sina=0, cic_period=4, cic_shift=16, chan_en=0xFF, ready=1 -> 16 words per frame, every I=4000, every Q=0, out_last on Q7, out_chan 0..7.
- Mask: chan_en=8'b00000101, same stimulus -> frame I0,Q0,I2,Q2 (4 words), out_last on Q2 only, chan=0,0,2,2.
- Saturation: adc=32767, cosa=131071, cic_period=4096, cic_shift=0 -> I=524287. Then adc=-32768 -> I=-524288. Q=0, no wrap.
- Backpressure: out_ready=0 for 2 windows (cic_period=40) -> first word held stable, frame_drop pulses once per blocked dump, drop_count=2. Release -> original frame completes intact.
- Period change: cic_period 8->16 mid-window -> current window still sums 8 products, next windows sum 16 (I doubles with constant input).
- Reset mid-frame: assert reset_n=0 during SEND -> out_valid=0 immediately, drop_count=0. After release, first frame appears 2 cycles after the first dump, value from a full fresh window.
